// File: rtl/player_cmd_arbiter_if.sv
// Command inputs and player-state outputs of player_cmd_arbiter.
// slave = arbiter side, master = command sources / consumers side.
interface player_cmd_arbiter_if;
  logic        bt_valid;
  logic [7:0]  bt_cmd;
  logic        key_valid;
  logic [2:0]  key_cmd;
  logic        i_finish_song;
  logic [2:0]  o_song_select;
  logic        o_pause;
  logic [3:0]  vol_level;
  logic [15:0] o_vol;
  logic        o_next;
  logic        o_pre;
  logic        o_vol_plus;
  logic        o_vol_dec;
  logic        o_busy;
  logic        o_drop;

  modport master (
    output bt_valid, bt_cmd, key_valid, key_cmd, i_finish_song,
    input  o_song_select, o_pause, vol_level, o_vol, o_next, o_pre,
           o_vol_plus, o_vol_dec, o_busy, o_drop
  );

  modport slave (
    input  bt_valid, bt_cmd, key_valid, key_cmd, i_finish_song,
    output o_song_select, o_pause, vol_level, o_vol, o_next, o_pre,
           o_vol_plus, o_vol_dec, o_busy, o_drop
  );
endinterface

// File: rtl/player_cmd_arbiter.sv
// Serialises bt/key/end-of-song commands into song index, pause and volume state.
//   state | meaning
//   IDLE  | pick one source per cycle, latch command
//   EXEC  | apply latched command (one cycle)
//   LOCK  | post-command lockout, LOCK_CYCLES cycles
module player_cmd_arbiter #(
  parameter int SONG_NUM    = 4,
  parameter int LOCK_CYCLES = 5000000,
  parameter int VOL_MAX     = 8
) (
  input logic           clk,
  input logic           rst_n,
  player_cmd_arbiter_if.slave bus
);

  localparam int            CW        = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
  localparam logic [CW-1:0] LOCK_LOAD = CW'(LOCK_CYCLES - 1);
  localparam logic [2:0]    SONG_LAST = 3'(SONG_NUM - 1);
  localparam logic [3:0]    VMAX      = 4'(VOL_MAX);

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_LOCK} state_e;
  typedef enum logic [2:0] {C_AUTO, C_PAUSE, C_NEXT, C_PRE, C_VUP, C_VDN, C_SEL} cmd_e;

  state_e          r_state;
  cmd_e            r_cmd;
  logic [2:0]      r_cmd_idx;
  logic [CW-1:0]   r_lock_cnt;
  logic            r_pend;
  logic [2:0]      r_song;
  logic            r_pause;
  logic [3:0]      r_vol_level;
  logic            r_next;
  logic            r_pre;
  logic            r_vol_plus;
  logic            r_vol_dec;
  logic            r_busy;
  logic            r_drop;

  logic            w_bt_ok;
  cmd_e            w_bt_cmd;
  logic [2:0]      w_bt_idx;
  logic            w_key_ok;
  cmd_e            w_key_cmd;
  logic            w_key_live;
  logic            w_finish;
  logic [7:0]      w_att;

  always_comb begin
    w_bt_ok  = 1'b1;
    w_bt_cmd = C_PAUSE;
    w_bt_idx = 3'd0;
    unique case (bus.bt_cmd)
      8'h01:   w_bt_cmd = C_PAUSE;
      8'h02:   w_bt_cmd = C_NEXT;
      8'h03:   w_bt_cmd = C_PRE;
      8'h04:   w_bt_cmd = C_VUP;
      8'h05:   w_bt_cmd = C_VDN;
      default: begin
        if ((bus.bt_cmd[7:3] == 5'b01000) && (int'(bus.bt_cmd[2:0]) < SONG_NUM)) begin
          w_bt_cmd = C_SEL;
          w_bt_idx = bus.bt_cmd[2:0];
        end else begin
          w_bt_ok = 1'b0;
        end
      end
    endcase
  end

  always_comb begin
    w_key_ok  = 1'b1;
    w_key_cmd = C_PAUSE;
    unique case (bus.key_cmd)
      3'd1:    w_key_cmd = C_PAUSE;
      3'd2:    w_key_cmd = C_NEXT;
      3'd3:    w_key_cmd = C_PRE;
      3'd4:    w_key_cmd = C_VUP;
      3'd5:    w_key_cmd = C_VDN;
      default: w_key_ok = 1'b0;
    endcase
  end

  // ignored key codes never count as a command, so they can never be dropped
  assign w_key_live = bus.key_valid && w_key_ok;
  assign w_finish   = bus.i_finish_song;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_cmd       <= C_AUTO;
      r_cmd_idx   <= 3'd0;
      r_lock_cnt  <= '0;
      r_pend      <= 1'b0;
      r_song      <= 3'd0;
      r_pause     <= 1'b0;
      r_vol_level <= 4'd0;
      r_next      <= 1'b0;
      r_pre       <= 1'b0;
      r_vol_plus  <= 1'b0;
      r_vol_dec   <= 1'b0;
      r_busy      <= 1'b0;
      r_drop      <= 1'b0;
    end else begin
      r_next     <= 1'b0;
      r_pre      <= 1'b0;
      r_vol_plus <= 1'b0;
      r_vol_dec  <= 1'b0;
      r_drop     <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (r_pend || w_finish) begin
            r_cmd   <= C_AUTO;
            r_pend  <= 1'b0;
            r_state <= S_EXEC;
            r_busy  <= 1'b1;
            if (bus.bt_valid || w_key_live) r_drop <= 1'b1;
          end else if (bus.bt_valid) begin
            if (w_bt_ok) begin
              r_cmd     <= w_bt_cmd;
              r_cmd_idx <= w_bt_idx;
              r_state   <= S_EXEC;
              r_busy    <= 1'b1;
            end
            if (!w_bt_ok || w_key_live) r_drop <= 1'b1;
          end else if (w_key_live) begin
            r_cmd   <= w_key_cmd;
            r_state <= S_EXEC;
            r_busy  <= 1'b1;
          end
        end
        S_EXEC: begin
          if (w_finish) r_pend <= 1'b1;
          if (bus.bt_valid || w_key_live) r_drop <= 1'b1;
          r_state    <= S_LOCK;
          r_lock_cnt <= LOCK_LOAD;
          unique case (r_cmd)
            C_AUTO: r_song <= (r_song == SONG_LAST) ? 3'd0 : r_song + 3'd1;
            C_NEXT: begin
              r_song  <= (r_song == SONG_LAST) ? 3'd0 : r_song + 3'd1;
              r_pause <= 1'b0;
              r_next  <= 1'b1;
            end
            C_PRE: begin
              r_song  <= (r_song == 3'd0) ? SONG_LAST : r_song - 3'd1;
              r_pause <= 1'b0;
              r_pre   <= 1'b1;
            end
            C_VUP: begin
              if (r_vol_level != 4'd0) begin
                r_vol_level <= r_vol_level - 4'd1;
                r_vol_plus  <= 1'b1;
              end
            end
            C_VDN: begin
              if (r_vol_level < VMAX) begin
                r_vol_level <= r_vol_level + 4'd1;
                r_vol_dec   <= 1'b1;
              end
            end
            C_PAUSE: begin
              r_pause    <= ~r_pause;
              r_state    <= S_IDLE;
              r_lock_cnt <= '0;
              r_busy     <= 1'b0;
            end
            C_SEL: begin
              r_song     <= r_cmd_idx;
              r_pause    <= 1'b0;
              r_state    <= S_IDLE;
              r_lock_cnt <= '0;
              r_busy     <= 1'b0;
            end
            default: r_state <= S_IDLE;
          endcase
        end
        S_LOCK: begin
          if (w_finish) r_pend <= 1'b1;
          if (bus.bt_valid || w_key_live) r_drop <= 1'b1;
          if (r_lock_cnt == '0) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_lock_cnt <= r_lock_cnt - 1'b1;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign w_att = (r_vol_level == VMAX) ? 8'hFC : 8'd14 * {4'd0, r_vol_level};

  assign bus.o_song_select = r_song;
  assign bus.o_pause       = r_pause;
  assign bus.vol_level     = r_vol_level;
  assign bus.o_vol         = {w_att, w_att};
  assign bus.o_next        = r_next;
  assign bus.o_pre         = r_pre;
  assign bus.o_vol_plus    = r_vol_plus;
  assign bus.o_vol_dec     = r_vol_dec;
  assign bus.o_busy        = r_busy;
  assign bus.o_drop        = r_drop;

endmodule

// File: doc/player_cmd_arbiter.md
Name: player_cmd_arbiter

Overview:
- Merges three command sources into one player-control state: UART/bluetooth command bytes, debounced on-board key codes, and the decoder's end-of-song flag.
- Owns song index, pause and volume attenuation.
- Serialises commands through a single-command FSM with a post-command lockout, so that only one source changes player state at a time.
- Sits between the UART receiver / key debouncer and the MP3 decoder-feed and display logic.

Parameters:
- SONG_NUM, 4: number of songs. Valid indices are 0..SONG_NUM-1, and SONG_NUM must be ≤8.
- LOCK_CYCLES, 5000000: lockout length in clk cycles after next, pre and volume commands. Must be ≥1.
- VOL_MAX, 8: maximum attenuation level. 0 is loudest.

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- bt_valid  in  1  one-cycle strobe: bt_cmd valid
- bt_cmd  in  8  bluetooth command byte
- key_valid  in  1  one-cycle strobe: key_cmd valid
- key_cmd  in  3  key command code
- i_finish_song  in  1  level/pulse from decoder: current song ended
- o_song_select  out  3  current song index
- o_pause  out  1  1 = paused
- vol_level  out  4  attenuation level 0..VOL_MAX
- o_vol  out  16  decoder volume word {att,att}
- o_next  out  1  one-cycle pulse: user next executed
- o_pre  out  1  one-cycle pulse: user previous executed
- o_vol_plus  out  1  one-cycle pulse: volume raised (level decremented)
- o_vol_dec  out  1  one-cycle pulse: volume lowered (level incremented)
- o_busy  out  1  1 while FSM not IDLE
- o_drop  out  1  one-cycle pulse: a bt/key command was discarded

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is synchronous and active-low.
- Reset values: all outputs 0; state IDLE; lock counter 0; pending-finish flag 0.

Command decode:
- bt_cmd codes:
  - 0x01 PAUSE
  - 0x02 NEXT
  - 0x03 PRE
  - 0x04 VOL_UP
  - 0x05 VOL_DN
  - 0x40+n SELECT n, for n<SONG_NUM
  - Any other byte, including 0x40+n with n≥SONG_NUM, is discarded with an o_drop pulse.
- key_cmd codes:
  - 1 PAUSE, 2 NEXT, 3 PRE, 4 VOL_UP, 5 VOL_DN
  - 0, 6 and 7 are ignored silently, with no o_drop.

FSM states: IDLE, EXEC, LOCK.

IDLE:
- Selects one source per cycle. Priority: pending finish or i_finish_song > bt_valid > key_valid.
- Latches the selected command and goes to EXEC in the next cycle.
- A lower-priority valid in the same cycle is discarded and pulses o_drop, except for ignored key codes.

EXEC (exactly 1 cycle):
- Applies the command. Register updates take effect at the end of EXEC.
- AUTO (finish):
  - song = (song==SONG_NUM-1) ? 0 : song+1.
  - o_pause unchanged; no pulse.
  - Next state LOCK.
- NEXT:
  - Same wrap as AUTO.
  - o_pause<=0; o_next pulse.
  - Next state LOCK.
- PRE:
  - song = (song==0) ? SONG_NUM-1 : song-1.
  - o_pause<=0; o_pre pulse.
  - Next state LOCK.
- VOL_UP:
  - If level>0: level-1 and o_vol_plus pulse.
  - At level 0: no change, no pulse.
  - Next state LOCK in both cases.
- VOL_DN:
  - If level<VOL_MAX: level+1 and o_vol_dec pulse.
  - At VOL_MAX: no change, no pulse.
  - Next state LOCK.
- PAUSE: toggle o_pause; next state IDLE (no lock).
- SELECT n: song<=n; o_pause<=0; next state IDLE (no lock).

LOCK:
- Counts LOCK_CYCLES cycles, then returns to IDLE with the counter cleared.

Timing:
- Valid sampled in IDLE at cycle N.
- EXEC at N+1.
- Updated outputs and the pulse visible at N+2. The pulse lasts only N+2.
- LOCK occupies N+2..N+1+LOCK_CYCLES.
- IDLE resumes at N+2+LOCK_CYCLES.
- o_busy is registered and is high exactly while state≠IDLE.

Busy handling:
- bt/key valid during EXEC or LOCK is discarded with an o_drop pulse one cycle later.
- i_finish_song high during EXEC or LOCK sets the sticky pending flag.
- The pending flag is serviced on the first IDLE cycle and cleared when captured.
- Multiple finishes during one busy period collapse to a single AUTO.

Volume word:
- att = (level==VOL_MAX) ? 8'hFC : 8'd14*level, truncated to 8 bits.
- o_vol = {att,att}. o_vol is combinational from vol_level.

Reset mid-operation:
- rst_n low in any state forces reset values at the next edge.
- Lock counter, pending flag and any in-flight command are discarded.

Test Plan:
- Bench parameters: LOCK_CYCLES=8, SONG_NUM=4.
1. Reset, then bt 0x02 at cycle N → o_next=1 only at N+2; song=1; o_busy high from N+1 to N+9; idle at N+10.
2. song=3, key NEXT → song=0 (wrap). Then key PRE after lock → song=3. o_pause cleared both times.
3. Five VOL_DN → level 5, o_vol=0x4646. Continue to level 8 → o_vol=0xFCFC. A ninth VOL_DN → level stays 8, no o_vol_dec pulse, lock still taken.
4. bt_valid and key_valid in the same IDLE cycle → bt command executed, o_drop pulse. bt 0x44 with SONG_NUM=4 → o_drop, song unchanged.
5. Finish pulse mid-LOCK plus a key NEXT during LOCK → key dropped (o_drop). AUTO runs on the first IDLE cycle: song +1, no o_next pulse.
6. PAUSE, then SELECT 0x42 → o_pause 1 then 0, song=2, no lock (o_busy for one cycle each). Reset asserted mid-LOCK → all outputs 0 at the next edge.
